// File: rtl/req_arbiter_8.sv
// req_arbiter_8: 8-client arbiter with fixed/round-robin priority, grant hold and bounded-tenure preemption
module req_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       prio_mode,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       idle
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  state_t     state;
  logic [2:0] rr_ptr;
  logic [7:0] hold_cnt;
  logic [7:0] others;
  logic [2:0] ptr;
  logic [2:0] nxt;
  logic       release_o;
  logic       preempt;
  logic       arb;
  function automatic logic [2:0] pick(input logic [7:0] vec, input logic [2:0] start);
    logic [2:0] r;
    logic [2:0] idx;
    r = start;
    for (int i = 7; i >= 0; i--) begin
      idx = start - 3'(i);
      if (vec[idx]) r = idx;
    end
    return r;
  endfunction
  // gnt is zero in IDLE, so others equals req there; on release req[owner] is already 0
  assign others    = req & ~gnt;
  assign ptr       = prio_mode ? rr_ptr : 3'd7;
  assign nxt       = pick(others, ptr);
  assign release_o = state == GRANT && !req[gnt_id];
  assign preempt   = state == GRANT && hold_cnt == HOLD_LAST && |others;
  assign arb       = (state == IDLE || release_o) ? |req : preempt;
  assign idle      = req == 8'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 8'd0;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      rr_ptr    <= 3'd7;
      hold_cnt  <= 8'd0;
    end else if (arb) begin
      state     <= GRANT;
      gnt       <= 8'd1 << nxt;
      gnt_id    <= nxt;
      gnt_valid <= 1'b1;
      rr_ptr    <= nxt - 3'd1;
      hold_cnt  <= 8'd0;
    end else if (release_o) begin
      state     <= IDLE;
      gnt       <= 8'd0;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
    end else if (state == GRANT && hold_cnt != HOLD_LAST) begin
      hold_cnt  <= hold_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_req_arbiter_8.sv
// tb_req_arbiter_8: scoreboard bench for req_arbiter_8 with MAX_HOLD=4
module tb_req_arbiter_8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'd0;
  logic       prio_mode = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       idle;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  req_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .prio_mode(prio_mode),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] idx_of(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic step(input string tag, input logic [7:0] r, input logic [7:0] exp_gnt);
    logic [7:0] e;
    req = r;
    exp_q.push_back(exp_gnt);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, " gnt"}, 32'(gnt), 32'(e));
    chk({tag, " gnt_id"}, 32'(gnt_id), 32'(idx_of(e)));
    chk({tag, " gnt_valid"}, 32'(gnt_valid), 32'(e != 8'd0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 8'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    prio_mode = 1'b0;
    req = 8'd0;
    rst_n = 1'b0;
    #2;
    chk("reset idle req0", 32'(idle), 32'd1);
    req = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset gnt", 32'(gnt), 32'd0);
    chk("reset gnt_id", 32'(gnt_id), 32'd0);
    chk("reset gnt_valid", 32'(gnt_valid), 32'd0);
    chk("reset idle", 32'(idle), 32'd0);
    rst_n = 1'b1;
    step("first", 8'hFF, 8'h80);
    step("fixed 2A", 8'h2A, 8'h20);
    step("fixed 0A", 8'h0A, 8'h08);
    step("fixed 02", 8'h02, 8'h02);
    step("fixed 00", 8'h00, 8'h00);
    chk("idle high", 32'(idle), 32'd1);

    do_reset();
    prio_mode = 1'b1;
    step("rr 7", 8'hFF, 8'h80);
    for (int k = 6; k >= 0; k--) step($sformatf("rr %0d", k), 8'hFF & ~(8'd1 << (k + 1)), 8'd1 << k);
    step("rr wrap", 8'hFE, 8'h80);

    for (int m = 1; m >= 0; m--) begin
      do_reset();
      prio_mode = m[0];
      for (int c = 0; c < 12; c++)
        step($sformatf("preempt m%0d c%0d", m, c), 8'h81, (c >= 4 && c < 8) ? 8'h01 : 8'h80);
    end

    for (int c = 0; c < 50; c++) step($sformatf("sole c%0d", c), 8'h10, 8'h10);

    step("own3", 8'h08, 8'h08);
    #2 rst_n = 1'b0;
    #1;
    chk("async gnt", 32'(gnt), 32'd0);
    chk("async gnt_valid", 32'(gnt_valid), 32'd0);
    chk("async gnt_id", 32'(gnt_id), 32'd0);
    #1 rst_n = 1'b1;
    prio_mode = 1'b1;
    step("after async", 8'h09, 8'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
